// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the 4-bit CPU bus: bus mux opcodes, ALU ops,
// destination codes and the transfer-unit FSM state type.
package cpu_bus_pkg;

  localparam logic [2:0] BUS_SEL_SWITCH = 3'b000;
  localparam logic [2:0] BUS_SEL_ROUT   = 3'b011;
  localparam logic [2:0] BUS_SEL_CONST3 = 3'b101;
  localparam logic [2:0] BUS_SEL_IDLE   = 3'b111;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    DST_A    = 2'b00,
    DST_B    = 2'b01,
    DST_OUT  = 2'b10,
    DST_NONE = 2'b11
  } dst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_LATCH = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/bus_alu4.sv
// Combinational ALU for the bus transfer unit: (op, dst, bus) -> (result, carry).
// Carry is the ADD carry-out or the SUB borrow; MOV and CLR clear it.
module bus_alu4
  import cpu_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext = '0;
    unique case (op)
      OP_MOV:  ext = {1'b0, bus};
      OP_ADD:  ext = {1'b0, dst} + {1'b0, bus};
      // Borrow falls out of the extended subtraction as the top bit
      OP_SUB:  ext = {1'b0, dst} - {1'b0, bus};
      OP_CLR:  ext = '0;
      default: ext = '0;
    endcase
    result = ext[WIDTH-1:0];
    carry  = ext[WIDTH];
  end

endmodule

// File: rtl/bus_transfer_unit.sv
// Sequenced bus consumer: drives a source opcode, waits a settle cycle, then
// captures (optionally combines) the bus value into A, B or OUT.
module bus_transfer_unit
  import cpu_bus_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       src_sel,
  input  logic [1:0]       dst_sel,
  input  logic [WIDTH-1:0] bus_value,
  output logic [2:0]       bus_selector,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] rout_out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [2:0]       src_q, src_d;
  dst_e             dst_q, dst_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic             carry_q, carry_d, zero_q, zero_d;
  logic [2:0]       sel_q, sel_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  always_comb begin
    operand = '0;
    unique case (dst_q)
      DST_A:    operand = a_q;
      DST_B:    operand = b_q;
      DST_OUT:  operand = out_q;
      DST_NONE: operand = '0;
      default:  operand = '0;
    endcase
  end

  bus_alu4 #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .dst    (operand),
    .bus    (bus_value),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    zero_d  = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          op_d    = op_e'(op);
          src_d   = src_sel;
          dst_d   = dst_e'(dst_sel);
        end
      end
      ST_DRIVE: state_d = ST_LATCH;
      ST_LATCH: begin
        state_d = ST_DONE;
        unique case (dst_q)
          DST_A:    a_d   = alu_result;
          DST_B:    b_d   = alu_result;
          DST_OUT:  out_d = alu_result;
          default:  ;
        endcase
        carry_d = alu_carry;
        zero_d  = (alu_result == '0);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if ((state_d == ST_DRIVE || state_d == ST_LATCH) && op_d != OP_CLR) sel_d = src_d;
    else                                                                sel_d = BUS_SEL_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MOV;
      src_q   <= BUS_SEL_IDLE;
      dst_q   <= DST_NONE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      sel_q   <= BUS_SEL_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus_selector = sel_q;
  assign reg_a        = a_q;
  assign reg_b        = b_q;
  assign rout_out     = out_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
